// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing and per-entry state layout.
package reorder_buffer_pkg;

    localparam int ROB_ENTRY_WIDTH_DEF = 3;
    localparam int ROB_DEPTH_DEF       = 1 << ROB_ENTRY_WIDTH_DEF;

    // One in-flight instruction as tracked between dispatch and retire.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        has_rd;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mispred;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / operand-query / commit signals of the ROB.
interface reorder_buffer_if #(parameter int W = 3);

    logic         alloc_valid;
    logic         alloc_has_rd;
    logic [4:0]   alloc_rd;
    logic         alloc_ready;
    logic [W-1:0] alloc_index;

    logic         wb_valid;
    logic [W-1:0] wb_index;
    logic [31:0]  wb_data;
    logic         wb_mispredict;
    logic [31:0]  wb_target;

    logic [W-1:0] qry_index1;
    logic [W-1:0] qry_index2;
    logic         qry_ready1;
    logic         qry_ready2;
    logic [31:0]  qry_data1;
    logic [31:0]  qry_data2;

    logic         commit_we;
    logic [4:0]   commit_addr;
    logic [31:0]  commit_data;
    logic [W-1:0] commit_index;
    logic         commit_valid;
    logic         rollback;
    logic [31:0]  rollback_pc;

    // Core side: dispatch, execution units and RAT.
    modport master (
        output alloc_valid, alloc_has_rd, alloc_rd,
        input  alloc_ready, alloc_index,
        output wb_valid, wb_index, wb_data, wb_mispredict, wb_target,
        output qry_index1, qry_index2,
        input  qry_ready1, qry_ready2, qry_data1, qry_data2,
        input  commit_we, commit_addr, commit_data, commit_index, commit_valid,
        input  rollback, rollback_pc
    );

    // ROB side.
    modport slave (
        input  alloc_valid, alloc_has_rd, alloc_rd,
        output alloc_ready, alloc_index,
        input  wb_valid, wb_index, wb_data, wb_mispredict, wb_target,
        input  qry_index1, qry_index2,
        output qry_ready1, qry_ready2, qry_data1, qry_data2,
        output commit_we, commit_addr, commit_data, commit_index, commit_valid,
        output rollback, rollback_pc
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the circular ROB.
module rob_ptr_ctrl #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alloc_valid,
    input  logic         retire,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [W-1:0] tail,
    output logic [W:0]   count,
    output logic         alloc_ready,
    output logic         alloc_fire
);

    localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

    // Fullness uses registered count so a same-cycle retire never frees a slot early.
    assign alloc_ready = (count != FULL) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Pointer and count update; flush snaps everything back to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) tail <= tail + W'(1);
            if (retire)     head <= head + W'(1);
            case ({alloc_fire, retire})
                2'b10:   count <= count + (W+1)'(1);
                2'b01:   count <= count - (W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, write back by index, retire at head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    reorder_buffer_if.slave   bus
);

    localparam int W     = ROB_ENTRY_WIDTH;
    localparam int DEPTH = 1 << W;

    rob_entry_t   rob [DEPTH];
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [W:0]   count;
    logic         alloc_fire;
    logic         retire;
    logic         flush;

    rob_ptr_ctrl #(.W(W)) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (bus.alloc_valid),
        .retire      (retire),
        .flush       (flush),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .alloc_ready (bus.alloc_ready),
        .alloc_fire  (alloc_fire)
    );

    assign bus.alloc_index = tail;

    // Head retires once its result is in; a mispredicted head flushes instead of writing.
    assign retire           = rob[head].busy && rob[head].done;
    assign flush            = retire && rob[head].mispred;
    assign bus.commit_valid = retire;
    assign bus.commit_we    = retire && rob[head].has_rd && (rob[head].rd != 5'd0)
                              && !rob[head].mispred;
    assign bus.commit_addr  = rob[head].rd;
    assign bus.commit_data  = rob[head].data;
    assign bus.commit_index = head;
    assign bus.rollback     = flush;
    assign bus.rollback_pc  = rob[head].target;

    // Operand queries see a same-cycle writeback ahead of the stored value.
    logic byp1, byp2;
    assign byp1           = bus.wb_valid && (bus.wb_index == bus.qry_index1);
    assign byp2           = bus.wb_valid && (bus.wb_index == bus.qry_index2);
    assign bus.qry_ready1 = byp1 || (rob[bus.qry_index1].busy && rob[bus.qry_index1].done);
    assign bus.qry_ready2 = byp2 || (rob[bus.qry_index2].busy && rob[bus.qry_index2].done);
    assign bus.qry_data1  = byp1 ? bus.wb_data : rob[bus.qry_index1].data;
    assign bus.qry_data2  = byp2 ? bus.wb_data : rob[bus.qry_index2].data;

    // Entry state: reset clears all, flush drops every entry and any same-cycle alloc/writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) rob[i].busy <= 1'b0;
        end else begin
            if (alloc_fire) begin
                rob[tail].busy    <= 1'b1;
                rob[tail].done    <= 1'b0;
                rob[tail].mispred <= 1'b0;
                rob[tail].has_rd  <= bus.alloc_has_rd;
                rob[tail].rd      <= bus.alloc_rd;
            end
            if (bus.wb_valid && rob[bus.wb_index].busy) begin
                rob[bus.wb_index].done    <= 1'b1;
                rob[bus.wb_index].data    <= bus.wb_data;
                rob[bus.wb_index].mispred <= bus.wb_mispredict;
                rob[bus.wb_index].target  <= bus.wb_target;
            end
            if (retire) rob[head].busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed checks of allocation, writeback, bypass, in-order commit, rollback and reset.
module tb_reorder_buffer;

    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer_if #(.W(W)) bus ();

    reorder_buffer #(.ROB_ENTRY_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid   = 1'b0;
        bus.alloc_has_rd  = 1'b0;
        bus.alloc_rd      = 5'd0;
        bus.wb_valid      = 1'b0;
        bus.wb_index      = '0;
        bus.wb_data       = 32'd0;
        bus.wb_mispredict = 1'b0;
        bus.wb_target     = 32'd0;
        bus.qry_index1    = '0;
        bus.qry_index2    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_wb(input logic [W-1:0] idx, input logic [31:0] d,
                          input logic mp, input logic [31:0] tgt);
        bus.wb_valid = 1'b1; bus.wb_index = idx; bus.wb_data = d;
        bus.wb_mispredict = mp; bus.wb_target = tgt;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.alloc_ready !== 1'b1) begin $display("FAIL rst_alloc_ready got=%b exp=1", bus.alloc_ready); bad++; end
        total++; if (bus.alloc_index !== 3'd0) begin $display("FAIL rst_alloc_index got=%0d exp=0", bus.alloc_index); bad++; end
        total++; if (bus.commit_valid !== 1'b0) begin $display("FAIL rst_commit_valid got=%b exp=0", bus.commit_valid); bad++; end
        total++; if (bus.commit_we !== 1'b0) begin $display("FAIL rst_commit_we got=%b exp=0", bus.commit_we); bad++; end
        total++; if (bus.rollback !== 1'b0) begin $display("FAIL rst_rollback got=%b exp=0", bus.rollback); bad++; end
        total++; if (bus.qry_ready1 !== 1'b0) begin $display("FAIL rst_qry_ready1 got=%b exp=0", bus.qry_ready1); bad++; end
    endtask

    task automatic test_in_order();
        logic [4:0]  exp_rd [3] = '{5'd5, 5'd6, 5'd7};
        logic [31:0] exp_d  [3] = '{32'h10, 32'h11, 32'h12};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = exp_rd[i];
            #1;
            total++; if (bus.alloc_index !== W'(i)) begin $display("FAIL order_alloc_index got=%0d exp=%0d", bus.alloc_index, i); bad++; end
            tick();
        end
        bus.alloc_valid = 1'b0;
        set_wb(3'd1, 32'h11, 1'b0, 32'h0);
        #1;
        total++; if (bus.commit_valid !== 1'b0) begin $display("FAIL order_early_commit got=%b exp=0", bus.commit_valid); bad++; end
        tick();
        set_wb(3'd0, 32'h10, 1'b0, 32'h0);
        #1;
        total++; if (bus.commit_valid !== 1'b0) begin $display("FAIL order_no_skip got=%b exp=0", bus.commit_valid); bad++; end
        tick();
        set_wb(3'd2, 32'h12, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({bus.commit_valid, bus.commit_we, bus.commit_addr, bus.commit_data, bus.commit_index} !== {2'b11, exp_rd[i], exp_d[i], W'(i)})
                begin $display("FAIL order_commit%0d got=v%b we%b r%0d d%h i%0d exp r%0d d%h i%0d", i, bus.commit_valid, bus.commit_we, bus.commit_addr, bus.commit_data, bus.commit_index, exp_rd[i], exp_d[i], i); bad++; end
            tick();
            bus.wb_valid = 1'b0;
        end
        #1;
        total++; if (bus.commit_valid !== 1'b0) begin $display("FAIL order_drained got=%b exp=0", bus.commit_valid); bad++; end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'(i + 1);
            #1;
            total++; if (bus.alloc_index !== W'(i)) begin $display("FAIL full_alloc_index got=%0d exp=%0d", bus.alloc_index, i); bad++; end
            tick();
        end
        bus.alloc_valid = 1'b0;
        set_wb(3'd0, 32'h1, 1'b0, 32'h0);
        #1;
        total++; if (bus.alloc_ready !== 1'b0) begin $display("FAIL full_ready got=%b exp=0", bus.alloc_ready); bad++; end
        tick();
        bus.wb_valid = 1'b0;
        bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd20;
        #1;
        total++; if (bus.commit_valid !== 1'b1) begin $display("FAIL full_retire_valid got=%b exp=1", bus.commit_valid); bad++; end
        total++; if (bus.alloc_ready !== 1'b0) begin $display("FAIL full_retire_no_alloc got=%b exp=0", bus.alloc_ready); bad++; end
        tick();
        #1;
        total++; if (bus.alloc_ready !== 1'b1) begin $display("FAIL wrap_ready got=%b exp=1", bus.alloc_ready); bad++; end
        total++; if (bus.alloc_index !== 3'd0) begin $display("FAIL wrap_index got=%0d exp=0", bus.alloc_index); bad++; end
        tick();
        bus.alloc_valid = 1'b0;
        #1;
        total++; if (bus.alloc_ready !== 1'b0) begin $display("FAIL refull_ready got=%b exp=0", bus.alloc_ready); bad++; end
        total++; if (bus.alloc_index !== 3'd1) begin $display("FAIL refull_index got=%0d exp=1", bus.alloc_index); bad++; end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'd3;
        repeat (4) tick();
        bus.alloc_valid = 1'b0;
        bus.qry_index1 = 3'd3; bus.qry_index2 = 3'd2;
        set_wb(3'd3, 32'hABCD, 1'b0, 32'h0);
        #1;
        total++; if (bus.qry_ready1 !== 1'b1) begin $display("FAIL byp_ready1 got=%b exp=1", bus.qry_ready1); bad++; end
        total++; if (bus.qry_data1 !== 32'hABCD) begin $display("FAIL byp_data1 got=%h exp=0000abcd", bus.qry_data1); bad++; end
        total++; if (bus.qry_ready2 !== 1'b0) begin $display("FAIL byp_ready2 got=%b exp=0", bus.qry_ready2); bad++; end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        total++; if ({bus.qry_ready1, bus.qry_data1} !== {1'b1, 32'hABCD}) begin $display("FAIL stored_q1 got=%b/%h exp=1/0000abcd", bus.qry_ready1, bus.qry_data1); bad++; end
        set_wb(3'd3, 32'h1234, 1'b0, 32'h0);
        #1;
        total++; if (bus.qry_data1 !== 32'h1234) begin $display("FAIL byp_wins got=%h exp=00001234", bus.qry_data1); bad++; end
    endtask

    task automatic test_no_rd();
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_has_rd = 1'b0; bus.alloc_rd = 5'd9; tick();
        bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'd0; tick();
        bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'd3; tick();
        bus.alloc_valid = 1'b0;
        set_wb(3'd0, 32'h5, 1'b0, 32'h0); tick();
        set_wb(3'd1, 32'h6, 1'b0, 32'h0);
        #1;
        total++; if ({bus.commit_valid, bus.commit_we} !== 2'b10) begin $display("FAIL store_commit got=v%b we%b exp=v1 we0", bus.commit_valid, bus.commit_we); bad++; end
        tick();
        set_wb(3'd2, 32'h7, 1'b0, 32'h0);
        #1;
        total++; if ({bus.commit_valid, bus.commit_we, bus.commit_index} !== {2'b10, 3'd1}) begin $display("FAIL rd0_commit got=v%b we%b i%0d exp=v1 we0 i1", bus.commit_valid, bus.commit_we, bus.commit_index); bad++; end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        total++; if ({bus.commit_we, bus.commit_addr, bus.commit_data} !== {1'b1, 5'd3, 32'h7}) begin $display("FAIL rd3_commit got=we%b r%0d d%h exp=we1 r3 d7", bus.commit_we, bus.commit_addr, bus.commit_data); bad++; end
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'(i + 1);
            tick();
        end
        bus.alloc_valid = 1'b0;
        set_wb(3'd1, 32'h55, 1'b1, 32'h200); tick();
        set_wb(3'd0, 32'h7, 1'b0, 32'h0); tick();
        bus.wb_valid = 1'b0;
        #1;
        total++; if ({bus.commit_valid, bus.commit_we, bus.commit_addr, bus.rollback} !== {2'b11, 5'd1, 1'b0}) begin $display("FAIL rb_pre_commit got=v%b we%b r%0d rb%b exp=v1 we1 r1 rb0", bus.commit_valid, bus.commit_we, bus.commit_addr, bus.rollback); bad++; end
        tick();
        set_wb(3'd2, 32'h99, 1'b0, 32'h0);
        bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd30;
        #1;
        total++; if ({bus.rollback, bus.rollback_pc} !== {1'b1, 32'h200}) begin $display("FAIL rb_pulse got=%b/%h exp=1/00000200", bus.rollback, bus.rollback_pc); bad++; end
        total++; if ({bus.commit_valid, bus.commit_we} !== 2'b10) begin $display("FAIL rb_no_write got=v%b we%b exp=v1 we0", bus.commit_valid, bus.commit_we); bad++; end
        total++; if (bus.alloc_ready !== 1'b0) begin $display("FAIL rb_alloc_blocked got=%b exp=0", bus.alloc_ready); bad++; end
        tick();
        idle_inputs();
        bus.qry_index1 = 3'd2;
        #1;
        total++; if ({bus.rollback, bus.commit_valid, bus.alloc_ready, bus.alloc_index} !== {3'b001, 3'd0}) begin $display("FAIL rb_after got=rb%b v%b rdy%b i%0d exp=rb0 v0 rdy1 i0", bus.rollback, bus.commit_valid, bus.alloc_ready, bus.alloc_index); bad++; end
        total++; if (bus.qry_ready1 !== 1'b0) begin $display("FAIL rb_wb_lost got=%b exp=0", bus.qry_ready1); bad++; end
        bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'd8;
        tick();
        bus.alloc_valid = 1'b0;
        set_wb(3'd0, 32'hBEEF, 1'b0, 32'h0); tick();
        bus.wb_valid = 1'b0;
        #1;
        total++; if ({bus.commit_we, bus.commit_index, bus.commit_addr, bus.commit_data} !== {1'b1, 3'd0, 5'd8, 32'hBEEF}) begin $display("FAIL rb_restart got=we%b i%0d r%0d d%h exp=we1 i0 r8 dbeef", bus.commit_we, bus.commit_index, bus.commit_addr, bus.commit_data); bad++; end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_has_rd = 1'b1; bus.alloc_rd = 5'(i + 10);
            tick();
        end
        bus.alloc_valid = 1'b0;
        set_wb(3'd0, 32'h3, 1'b1, 32'h40); tick();
        bus.wb_valid = 1'b0;
        #1;
        total++; if (bus.rollback !== 1'b1) begin $display("FAIL rstmid_rb_pending got=%b exp=1", bus.rollback); bad++; end
        rst = 1'b1; bus.alloc_valid = 1'b1;
        tick();
        rst = 1'b0; bus.alloc_valid = 1'b0; bus.qry_index1 = 3'd0;
        #1;
        total++; if ({bus.alloc_ready, bus.commit_valid, bus.alloc_index, bus.rollback} !== {2'b10, 3'd0, 1'b0}) begin $display("FAIL rstmid got=rdy%b v%b i%0d rb%b exp=rdy1 v0 i0 rb0", bus.alloc_ready, bus.commit_valid, bus.alloc_index, bus.rollback); bad++; end
        total++; if (bus.qry_ready1 !== 1'b0) begin $display("FAIL rstmid_qry got=%b exp=0", bus.qry_ready1); bad++; end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_bypass();
        test_no_rd();
        test_rollback();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
